// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep peak tracker: controller states and
// default sizing used by the interface, the top level and the bench.
package sweep_pkg;

    localparam int NCH_DEF   = 2;
    localparam int MAG_W_DEF = 16;
    localparam int IDX_W_DEF = 10;

    // Sweep controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/sweep_peak_tracker_if.sv
// Measurement-engine link: request handshake out, response strobe back.
interface sweep_peak_tracker_if import sweep_pkg::*; #(
    parameter int NCH   = NCH_DEF,
    parameter int MAG_W = MAG_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) ();

    logic                   meas_req_valid;
    logic                   meas_req_ready;
    logic [IDX_W-1:0]       meas_req_idx;
    logic                   meas_rsp_valid;
    logic [NCH*MAG_W-1:0]   meas_rsp_mag;

    // Tracker side: issues requests, consumes responses
    modport master (
        output meas_req_valid,
        output meas_req_idx,
        input  meas_req_ready,
        input  meas_rsp_valid,
        input  meas_rsp_mag
    );

    // Measurement engine side
    modport slave (
        input  meas_req_valid,
        input  meas_req_idx,
        output meas_req_ready,
        output meas_rsp_valid,
        output meas_rsp_mag
    );

endinterface

// File: rtl/peak_hold_ch.sv
// One channel of peak tracking: holds the largest magnitude seen in the
// current sweep and the sweep index at which it first occurred.
module peak_hold_ch #(
    parameter int MAG_W = 16,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             upd,
    input  logic             first,
    input  logic [MAG_W-1:0] mag_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic [MAG_W-1:0] peak_mag,
    output logic [IDX_W-1:0] peak_idx
);

    // Clear on sweep launch; first point loads, later points need a strict win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (clr) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (upd && (first || (mag_in > peak_mag))) begin
            peak_mag <= mag_in;
            peak_idx <= idx_in;
        end
    end

endmodule

// File: rtl/sweep_peak_tracker.sv
// Sweep controller: steps an index from start to stop, requests one
// measurement per point and tracks the per-channel peak response.
module sweep_peak_tracker import sweep_pkg::*; #(
    parameter int NCH   = NCH_DEF,
    parameter int MAG_W = MAG_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IDX_W-1:0]      idx_start,
    input  logic [IDX_W-1:0]      idx_stop,
    input  logic [IDX_W-1:0]      idx_step,
    sweep_peak_tracker_if.master  meas,
    output logic [NCH*MAG_W-1:0]  peak_mag,
    output logic [NCH*IDX_W-1:0]  peak_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg
);

    sweep_state_t          state;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      cfg_stop;
    logic [IDX_W-1:0]      cfg_step;
    logic                  first_pt;
    logic [NCH*MAG_W-1:0]  mag_cap;

    logic                  cfg_bad;
    logic                  clr_peaks;
    logic                  upd_peaks;
    logic [IDX_W:0]        next_idx;

    // Configuration is judged on the raw inputs in the launch cycle only
    assign cfg_bad   = (idx_step == '0) || (idx_start > idx_stop);
    assign clr_peaks = (state == ST_IDLE) && start && !cfg_bad;
    // An abort during UPDATE wins, so that point is dropped from the peaks
    assign upd_peaks = (state == ST_UPDATE) && !abort;
    // One extra bit so a step past the top of the index range cannot wrap
    assign next_idx  = {1'b0, cur_idx} + {1'b0, cfg_step};

    assign meas.meas_req_valid = (state == ST_REQ);
    assign meas.meas_req_idx   = cur_idx;
    assign busy                = (state != ST_IDLE);
    assign done                = (state == ST_DONE);

    // Sweep sequencing, configuration capture and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_idx  <= '0;
            cfg_stop <= '0;
            cfg_step <= '0;
            first_pt <= 1'b0;
            err_cfg  <= 1'b0;
            mag_cap  <= '0;
        end else begin
            err_cfg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_stop <= idx_stop;
                        cfg_step <= idx_step;
                        if (cfg_bad) begin
                            err_cfg <= 1'b1;
                        end else begin
                            cur_idx  <= idx_start;
                            first_pt <= 1'b1;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (meas.meas_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (meas.meas_rsp_valid) begin
                        mag_cap <= meas.meas_rsp_mag;
                        state   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        first_pt <= 1'b0;
                        if (next_idx > {1'b0, cfg_stop}) begin
                            state <= ST_DONE;
                        end else begin
                            cur_idx <= next_idx[IDX_W-1:0];
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        peak_hold_ch #(
            .MAG_W (MAG_W),
            .IDX_W (IDX_W)
        ) u_peak (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr_peaks),
            .upd      (upd_peaks),
            .first    (first_pt),
            .mag_in   (mag_cap[c*MAG_W +: MAG_W]),
            .idx_in   (cur_idx),
            .peak_mag (peak_mag[c*MAG_W +: MAG_W]),
            .peak_idx (peak_idx[c*IDX_W +: IDX_W])
        );
    end

endmodule

// File: tb/tb_sweep_peak_tracker.sv
// Bench for sweep_peak_tracker: randomized measurement engine, a list-based
// reference model of sweep indices and per-channel peaks, and a small
// 4-bit-index instance for the wrap-around case.
module tb_sweep_peak_tracker;
    import sweep_pkg::*;

    localparam int NCH   = 2;
    localparam int MAG_W = 16;
    localparam int IDX_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start, abort;
    logic [IDX_W-1:0]     idx_start, idx_stop, idx_step;
    logic [NCH*MAG_W-1:0] peak_mag;
    logic [NCH*IDX_W-1:0] peak_idx;
    logic                 busy, done, err_cfg;

    sweep_peak_tracker_if #(.NCH(NCH), .MAG_W(MAG_W), .IDX_W(IDX_W)) mif ();

    sweep_peak_tracker #(.NCH(NCH), .MAG_W(MAG_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .idx_start(idx_start), .idx_stop(idx_stop), .idx_step(idx_step),
        .meas(mif), .peak_mag(peak_mag), .peak_idx(peak_idx),
        .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    // Narrow instance: 4-bit index, one channel
    logic       start4, abort4;
    logic [3:0] s4_start, s4_stop, s4_step;
    logic [7:0] pm4;
    logic [3:0] pi4;
    logic       busy4, done4, err4;

    sweep_peak_tracker_if #(.NCH(1), .MAG_W(8), .IDX_W(4)) if4 ();

    sweep_peak_tracker #(.NCH(1), .MAG_W(8), .IDX_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .idx_start(s4_start), .idx_stop(s4_stop), .idx_step(s4_step),
        .meas(if4), .peak_mag(pm4), .peak_idx(pi4),
        .busy(busy4), .done(done4), .err_cfg(err4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model state
    logic [MAG_W-1:0] mag_tab [NCH][1024];
    int               pts[$];
    int               exp_q[$];
    logic [MAG_W-1:0] exp_pm [NCH];
    int               exp_pi [NCH];

    // Peak of each channel over the first npts sweep points; earliest wins ties
    function automatic void model_peaks(input int npts);
        for (int c = 0; c < NCH; c++) begin
            int best;
            int bi;
            best = -1;
            bi   = 0;
            for (int k = 0; k < npts; k++) begin
                if (int'(mag_tab[c][pts[k]]) > best) begin
                    best = int'(mag_tab[c][pts[k]]);
                    bi   = pts[k];
                end
            end
            exp_pm[c] = MAG_W'(best);
            exp_pi[c] = bi;
        end
    endfunction

    function automatic void model_points(input int s, input int e, input int st);
        pts.delete();
        for (int i = s; i <= e; i += st) pts.push_back(i);
    endfunction

    // Measurement engine for the main instance
    int force_rdy = -1;
    initial begin
        mif.meas_req_ready = 1'b0;
        mif.meas_rsp_valid = 1'b0;
        mif.meas_rsp_mag   = '0;
        forever begin
            @(posedge clk); #1;
            if (mif.meas_req_valid && rst_n) begin
                int               rd;
                int               sd;
                logic [IDX_W-1:0] ri;
                ri = mif.meas_req_idx;
                rd = (force_rdy >= 0) ? force_rdy : int'($urandom_range(0, 2));
                force_rdy = -1;
                sd = int'($urandom_range(0, 3));
                repeat (rd) begin @(posedge clk); #1; end
                mif.meas_req_ready = 1'b1;
                @(posedge clk); #1;
                mif.meas_req_ready = 1'b0;
                repeat (sd) begin @(posedge clk); #1; end
                mif.meas_rsp_valid = 1'b1;
                for (int c = 0; c < NCH; c++) mif.meas_rsp_mag[c*MAG_W +: MAG_W] = mag_tab[c][ri];
                @(posedge clk); #1;
                mif.meas_rsp_valid = 1'b0;
                mif.meas_rsp_mag   = {NCH*MAG_W{1'b1}};
            end
        end
    end

    // Measurement engine for the narrow instance: magnitude = 7 * index
    initial begin
        if4.meas_req_ready = 1'b0;
        if4.meas_rsp_valid = 1'b0;
        if4.meas_rsp_mag   = '0;
        forever begin
            @(posedge clk); #1;
            if (if4.meas_req_valid && rst_n) begin
                logic [3:0] ri4;
                ri4 = if4.meas_req_idx;
                if4.meas_req_ready = 1'b1;
                @(posedge clk); #1;
                if4.meas_req_ready = 1'b0;
                if4.meas_rsp_valid = 1'b1;
                if4.meas_rsp_mag   = 8'(int'(ri4) * 7);
                @(posedge clk); #1;
                if4.meas_rsp_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare process
    int               done_cnt = 0, err_cnt = 0, acc_cnt = 0, done4_cnt = 0;
    int               q4[$];
    logic             hold_prev = 1'b0;
    logic [IDX_W-1:0] prev_idx = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("req_valid_held", mif.meas_req_valid, 1);
                    chk("req_idx_held", mif.meas_req_idx, prev_idx);
                end
                if (!busy) chk("idle_no_req", mif.meas_req_valid, 0);
                if (mif.meas_req_valid && mif.meas_req_ready && !abort) begin
                    acc_cnt++;
                    chk("req_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("req_idx", mif.meas_req_idx, exp_q.pop_front());
                end
                hold_prev = mif.meas_req_valid && !mif.meas_req_ready && !abort;
                prev_idx  = mif.meas_req_idx;
                if (done) begin
                    done_cnt++;
                    chk("done_after_last_point", exp_q.size(), 0);
                    for (int c = 0; c < NCH; c++) begin
                        chk($sformatf("done_peak_mag%0d", c), peak_mag[c*MAG_W +: MAG_W], exp_pm[c]);
                        chk($sformatf("done_peak_idx%0d", c), peak_idx[c*IDX_W +: IDX_W], exp_pi[c]);
                    end
                end
                if (err_cfg) err_cnt++;
                if (if4.meas_req_valid && if4.meas_req_ready) q4.push_back(int'(if4.meas_req_idx));
                if (done4) done4_cnt++;
            end
        end
    end

    task automatic check_peaks(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_mag%0d", tag, c), peak_mag[c*MAG_W +: MAG_W], exp_pm[c]);
            chk($sformatf("%s_idx%0d", tag, c), peak_idx[c*IDX_W +: IDX_W], exp_pi[c]);
        end
    endtask

    task automatic launch(input int s, input int e, input int st);
        @(posedge clk); #1;
        idx_start = IDX_W'(s);
        idx_stop  = IDX_W'(e);
        idx_step  = IDX_W'(st);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        idx_start = IDX_W'($urandom);
        idx_stop  = IDX_W'($urandom);
        idx_step  = IDX_W'($urandom);
    endtask

    task automatic run_sweep(input int s, input int e, input int st);
        int target;
        int base;
        int budget;
        model_points(s, e, st);
        exp_q  = pts;
        model_peaks(pts.size());
        target = done_cnt + 1;
        base   = acc_cnt;
        budget = 14 * pts.size() + 30;
        launch(s, e, st);
        @(negedge clk);
        chk("peaks_cleared_mag", peak_mag, 0);
        chk("peaks_cleared_idx", peak_idx, 0);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
        chk("done_within_budget", done_cnt >= target, 1);
        chk("request_count", acc_cnt - base, pts.size());
        repeat (3) @(negedge clk);
        chk("done_single_pulse", done_cnt, target);
        chk("idle_after_done", busy, 0);
        check_peaks("peak_hold");
    endtask

    task automatic cfg_err(input int s, input int e, input int st);
        int eb;
        int ab;
        eb = err_cnt;
        ab = acc_cnt;
        @(posedge clk); #1;
        idx_start = IDX_W'(s);
        idx_stop  = IDX_W'(e);
        idx_step  = IDX_W'(st);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        @(negedge clk);
        chk("err_cfg_pulse", err_cfg, 1);
        chk("err_busy", busy, 0);
        chk("err_no_req", mif.meas_req_valid, 0);
        @(negedge clk);
        chk("err_cfg_one_cycle", err_cfg, 0);
        chk("err_busy_after", busy, 0);
        repeat (3) @(negedge clk);
        chk("err_pulse_count", err_cnt - eb, 1);
        chk("err_no_accept", acc_cnt - ab, 0);
        check_peaks("err_peaks_kept");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dc;
        int exp4[$];

        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        idx_start = '0; idx_stop = '0; idx_step = '0;
        start4 = 1'b0; abort4 = 1'b0; s4_start = '0; s4_stop = '0; s4_step = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cfg", err_cfg, 0);
        chk("rst_req_valid", mif.meas_req_valid, 0);
        chk("rst_req_idx", mif.meas_req_idx, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_idx", peak_idx, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Two channels with distinct peak positions
        for (int i = 0; i < 1024; i++) begin
            mag_tab[0][i] = MAG_W'($urandom_range(0, 499));
            mag_tab[1][i] = MAG_W'($urandom_range(0, 799));
        end
        mag_tab[0][6] = 16'd500;
        mag_tab[1][2] = 16'd800;
        run_sweep(0, 9, 1);
        chk("basic_pts", pts.size(), 10);
        chk("basic_peak_mag0", peak_mag[15:0], 500);
        chk("basic_peak_mag1", peak_mag[31:16], 800);
        chk("basic_peak_idx0", peak_idx[9:0], 6);
        chk("basic_peak_idx1", peak_idx[19:10], 2);

        // Tie on channel 0: earliest index must be kept
        for (int i = 0; i < 1024; i++) begin
            mag_tab[0][i] = MAG_W'($urandom_range(0, 299));
            mag_tab[1][i] = MAG_W'($urandom);
        end
        mag_tab[0][3] = 16'd300;
        mag_tab[0][7] = 16'd300;
        run_sweep(0, 9, 1);
        chk("tie_model_idx0", exp_pi[0], 3);
        chk("tie_peak_idx0", peak_idx[9:0], 3);
        chk("tie_peak_mag0", peak_mag[15:0], 300);

        // Rejected configurations
        cfg_err(0, 9, 0);
        cfg_err(12, 4, 1);

        // Randomized sweeps, including index-range top and frequent ties
        for (int t = 0; t < 6; t++) begin
            int s;
            int e;
            int st;
            for (int i = 0; i < 1024; i++)
                for (int c = 0; c < NCH; c++)
                    mag_tab[c][i] = (t % 2 == 0) ? MAG_W'($urandom) : MAG_W'($urandom_range(0, 7));
            s  = int'($urandom_range(0, 900));
            e  = s + int'($urandom_range(0, 120));
            st = int'($urandom_range(1, 25));
            run_sweep(s, e, st);
        end
        run_sweep(1020, 1023, 8);
        chk("carry_pts", pts.size(), 1);
        run_sweep(1000, 1023, 12);
        chk("top_pts", pts.size(), 2);
        run_sweep(5, 5, 3);

        // Long ready stall on the first point, then abort after three points
        for (int i = 0; i < 10; i++) begin
            mag_tab[0][i] = (i == 0) ? 16'd10 : (i == 1) ? 16'd40 : (i == 2) ? 16'd20 : 16'd1000;
            mag_tab[1][i] = (i < 3) ? 16'd5 : 16'd900;
        end
        model_points(0, 9, 1);
        exp_q = pts;
        base  = acc_cnt;
        dc    = done_cnt;
        force_rdy = 5;
        launch(0, 9, 1);
        for (int k = 0; k < 200; k++) begin
            if (acc_cnt >= base + 3) break;
            @(negedge clk);
        end
        chk("abort_three_points", acc_cnt - base, 3);
        force_rdy = 4;
        @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            if (mif.meas_req_valid) break;
            @(negedge clk);
        end
        chk("abort_fourth_req", mif.meas_req_valid, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        model_peaks(3);
        chk("abort_model_mag0", exp_pm[0], 40);
        chk("abort_model_idx0", exp_pi[0], 1);
        chk("abort_model_mag1", exp_pm[1], 5);
        chk("abort_model_idx1", exp_pi[1], 0);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_req_dropped", mif.meas_req_valid, 0);
        check_peaks("abort_partial");
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt, dc);
        chk("stray_rsp_busy", busy, 0);
        chk("abort_req_count", acc_cnt - base, 3);
        check_peaks("stray_rsp_peaks");

        // Reset while waiting for a response
        for (int i = 0; i < 1024; i++)
            for (int c = 0; c < NCH; c++) mag_tab[c][i] = MAG_W'($urandom);
        model_points(0, 9, 1);
        exp_q = pts;
        base  = acc_cnt;
        dc    = done_cnt;
        launch(0, 9, 1);
        for (int k = 0; k < 50; k++) begin
            if (acc_cnt > base) break;
            @(negedge clk);
        end
        chk("rstmid_first_accept", acc_cnt - base, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_err", err_cfg, 0);
        chk("rstmid_req_valid", mif.meas_req_valid, 0);
        chk("rstmid_req_idx", mif.meas_req_idx, 0);
        chk("rstmid_peak_mag", peak_mag, 0);
        chk("rstmid_peak_idx", peak_idx, 0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstmid_no_done", done_cnt, dc);
        chk("rstmid_idle", busy, 0);

        // Narrow index: 14 + 4 would wrap to 2 in four bits
        exp4.delete();
        for (int i = 10; i <= 15; i += 4) exp4.push_back(i);
        q4.delete();
        @(posedge clk); #1;
        s4_start = 4'd10; s4_stop = 4'd15; s4_step = 4'd4; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; s4_start = 4'd0; s4_stop = 4'd0; s4_step = 4'd1;
        for (int k = 0; k < 60; k++) begin
            if (done4_cnt > 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("w4_done_count", done4_cnt, 1);
        chk("w4_req_count", q4.size(), exp4.size());
        chk("w4_req_count_lit", q4.size(), 2);
        for (int i = 0; i < q4.size() && i < exp4.size(); i++)
            chk($sformatf("w4_req_idx%0d", i), q4[i], exp4[i]);
        chk("w4_peak_mag", pm4, 98);
        chk("w4_peak_idx", pi4, 14);
        chk("w4_idle", busy4, 0);
        chk("w4_no_err", err4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_peak_tracker.md
SWEEP_PEAK_TRACKER -- requirements
Module: sweep_peak_tracker

Interface
REQ-001 Parameter NCH, default 2: number of independent response channels (1..8).
REQ-002 Parameter MAG_W, default 16: unsigned magnitude width per channel.
REQ-003 Parameter IDX_W, default 10: sweep point index width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset; one clock, reset asynchronous active-low.
REQ-006 start  in  1  single-cycle sweep launch; honoured only in IDLE.
REQ-007 abort  in  1  terminate sweep; honoured in any non-IDLE state.
REQ-008 idx_start  in  IDX_W  first sweep index.
REQ-009 idx_stop  in  IDX_W  last permitted sweep index (inclusive).
REQ-010 idx_step  in  IDX_W  index increment.
REQ-011 meas_req_valid  out  1  measurement request valid.
REQ-012 meas_req_ready  in  1  measurement engine accepts request.
REQ-013 meas_req_idx  out  IDX_W  index of requested point.
REQ-014 meas_rsp_valid  in  1  response strobe, one cycle.
REQ-015 meas_rsp_mag  in  NCH*MAG_W  per-channel magnitudes, channel 0 in LSBs.
REQ-016 peak_mag  out  NCH*MAG_W  per-channel maximum magnitude so far.
REQ-017 peak_idx  out  NCH*IDX_W  per-channel index of that maximum.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse on normal sweep completion.
REQ-020 err_cfg  out  1  one-cycle pulse on rejected configuration.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, UPDATE, DONE.
REQ-022 IDLE + start: config SHALL be latched; if idx_step==0 or idx_start>idx_stop, err_cfg pulses next cycle and FSM stays IDLE, else peaks clear, cur_idx=idx_start, go REQ.
REQ-023 REQ: meas_req_valid=1 with meas_req_idx=cur_idx, held stable until meas_req_ready sampled high, then go WAIT.
REQ-024 WAIT: on meas_rsp_valid, all NCH magnitudes SHALL be captured and FSM goes UPDATE; rsp_valid in any other state SHALL be ignored.
REQ-025 UPDATE: per channel, first point of sweep unconditionally loads; thereafter load only if captured mag > peak_mag (strict; earliest index wins ties).
REQ-026 Next index SHALL be computed at IDX_W+1 bits; if cur_idx+idx_step > idx_stop or carries out, go DONE, else cur_idx advances and go REQ.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; peak outputs hold until next accepted start.
REQ-028 abort SHALL force IDLE next cycle without done, drop meas_req_valid, and leave partial peaks visible.
REQ-029 abort and start same cycle in IDLE: start wins (abort meaningless in IDLE); abort wins in all other states.
REQ-030 Config input changes after acceptance SHALL not affect the running sweep.
REQ-031 Per-point latency SHALL be REQ handshake + response wait + 1 UPDATE cycle; no internal back-to-back pipelining.

Reset
REQ-032 Reset SHALL force IDLE; busy, done, err_cfg, meas_req_valid = 0; meas_req_idx, peak_mag, peak_idx, cur_idx = 0.
REQ-033 Reset asserted mid-sweep SHALL discard the sweep with no done pulse.

Structure
REQ-034 State enum and NCH/MAG_W/IDX_W defaults SHALL live in shared package sweep_pkg.
REQ-035 Per-channel compare/hold SHALL be sub-module peak_hold_ch, instantiated NCH times by generate.

Verification
REQ-036 start=0, stop=9, step=1, NCH=2, ch0 mags peak 500 at idx 6, ch1 peak 800 at idx 2 -> 10 requests, peak_idx={2,6}, peak_mag={800,500}, one done.
REQ-037 Tie: ch0 mag 300 at idx 3 and idx 7 -> peak_idx0=3.
REQ-038 step=0 or start=12>stop=4 -> err_cfg one cycle, no meas_req_valid, busy stays 0.
REQ-039 IDX_W=4, start=10, stop=15, step=4 -> requests at 10,14 only, done, no wrap to 2.
REQ-040 meas_req_ready held low 5 cycles -> valid/idx stable throughout; abort after third point -> IDLE, no done, peaks reflect 3 points.
REQ-041 rst_n low during WAIT -> all outputs zero immediately; stray meas_rsp_valid in IDLE ignored.
